// File: rtl/pipeline_stall_ctrl_if.sv
// Signal bundle between the MIPS pipeline and pipeline_stall_ctrl.
// The pipeline (master) presents the ID/EX decode facts; the controller
// (slave) returns PC/pipeline-register controls, mul/div strobes and
// the performance counters.
interface pipeline_stall_ctrl_if;
  logic [4:0]  id_rs_a;
  logic [4:0]  id_rt_a;
  logic        id_is_muldiv;
  logic        id_is_div;
  logic        id_reads_hilo;
  logic        ex_MemRead;
  logic [4:0]  ex_rt_a;
  logic        ex_branch_taken;

  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        md_start;
  logic        md_is_div;
  logic        md_busy;
  logic        hilo_we;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs_a, id_rt_a, id_is_muldiv, id_is_div, id_reads_hilo,
           ex_MemRead, ex_rt_a, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           md_start, md_is_div, md_busy, hilo_we,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs_a, id_rt_a, id_is_muldiv, id_is_div, id_reads_hilo,
           ex_MemRead, ex_rt_a, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           md_start, md_is_div, md_busy, hilo_we,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Resolves load-use hazards, applies branch flushes and sequences the
// multi-cycle mul/div unit, stalling HI/LO consumers in ID until the
// result is written.
// Optional feature macro: PIPE_PERF_CNT_EN enables the saturating
// stall_cycles / flush_count counters; when undefined both read 0.
module pipeline_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // The counter is loaded with latency-1 so BUSY lasts exactly L cycles.
  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] DIV_CNT_INIT = 8'(DIV_LATENCY - 1);

  md_state_t  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       md_is_div_q, md_is_div_nxt;

  logic load_use;
  logic md_hazard;
  logic md_busy;
  logic md_start;
  logic hilo_we;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;

  assign load_use  = bus.ex_MemRead && (bus.ex_rt_a != 5'd0) &&
                     ((bus.ex_rt_a == bus.id_rs_a) || (bus.ex_rt_a == bus.id_rt_a));
  assign md_busy   = (state != IDLE);
  assign md_hazard = md_busy && (bus.id_is_muldiv || bus.id_reads_hilo);
  // A running operation is older than the branch, so the branch never
  // aborts it; it only suppresses launching the wrong-path instruction.
  assign md_start  = bus.id_is_muldiv && !bus.ex_branch_taken && !load_use && !md_busy;

  // Pipeline control: flush beats stall beats normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (bus.ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use || md_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Mul/div sequencer state, latency counter and latched operation type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      md_is_div_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      md_is_div_q <= md_is_div_nxt;
    end
  end

  // Mul/div sequencer next state: launch, count down, strobe HI/LO once.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    md_is_div_nxt = md_is_div_q;
    hilo_we       = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt     = BUSY;
          cnt_nxt       = bus.id_is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
          md_is_div_nxt = bus.id_is_div;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        hilo_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.md_start     = md_start;
  assign bus.md_is_div    = md_is_div_q;
  assign bus.md_busy      = md_busy;
  assign bus.hilo_we      = hilo_we;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters of frozen-PC cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline sequencing controller for the 5-stage MIPS core; sits beside the EX-stage forwarding logic and handles hazards that forwarding cannot resolve. It detects load-use hazards and applies branch flushes. It also owns the multi-cycle multiply/divide unit: it launches operations, counts their latency, and stalls dependent instructions in ID until HI/LO is written. Its outputs drive the PC register, the IF/ID and ID/EX pipeline registers, and the mul/div unit start and writeback strobes.

## Interface
Parameters:
- MUL_LATENCY, 4: EX cycles a multiply occupies the mul/div unit; legal range 1..255
- DIV_LATENCY, 32: EX cycles a divide occupies the mul/div unit; legal range 1..255

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs_a  in  5  rs register address of the instruction in ID
- id_rt_a  in  5  rt register address of the instruction in ID
- id_is_muldiv  in  1  instruction in ID is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_muldiv: 1 = divide, 0 = multiply
- id_reads_hilo  in  1  instruction in ID is mfhi/mflo
- ex_MemRead  in  1  instruction in EX is a load
- ex_rt_a  in  5  destination (rt) of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  clear IF/ID to a nop
- id_ex_bubble  out  1  load a nop into ID/EX
- md_start  out  1  one-cycle launch pulse to the mul/div unit
- md_is_div  out  1  operation type latched at launch
- md_busy  out  1  mul/div unit occupied
- hilo_we  out  1  one-cycle HI/LO write strobe
- stall_cycles  out  32  perf counter (see Configuration)
- flush_count  out  32  perf counter (see Configuration)

## Operation
- Hazard terms (combinational):
  - load_use = ex_MemRead && ex_rt_a!=0 && (ex_rt_a==id_rs_a || ex_rt_a==id_rt_a)
  - md_hazard = md_busy && (id_is_muldiv || id_reads_hilo)
- Priority, applied in order:
  - flush: ex_branch_taken → if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; any stall is ignored
  - stall: otherwise, load_use || md_hazard → pc_write=0, if_id_write=0, id_ex_bubble=1
  - normal: otherwise pc_write=1, if_id_write=1, all other control outputs 0
- Launch: md_start = id_is_muldiv && !ex_branch_taken && !load_use && !md_busy.
- FSM states:
  - IDLE: md_start → BUSY; loads cnt=(id_is_div ? DIV_LATENCY : MUL_LATENCY)-1 and md_is_div=id_is_div
  - BUSY: cnt decrements each cycle; when cnt==0 → DONE
  - DONE: hilo_we=1; → IDLE unconditionally
- md_busy = (state!=IDLE).
- cnt is 8 bits wide; it never wraps because the exit condition is cnt==0.
- ex_branch_taken does not abort an operation that is already running: that operation is older than the branch.
- Reset (async, any time, including mid-operation):
  - state=IDLE, cnt=0, md_is_div=0, counters=0
  - the pending operation is dropped and hilo_we is not issued
  - with all inputs 0, outputs read pc_write=1, if_id_write=1, all others 0

## Timing
- All hazard, stall and flush outputs are combinational in the same cycle.
- md_start is asserted in cycle N:
  - md_busy=1 from N+1 through N+L+1, where L is the selected latency
  - BUSY occupies N+1..N+L
  - hilo_we=1 in N+L+1
  - IDLE from N+L+2
- A dependent mfhi in ID is stalled until N+L+2, when it advances.
- A second muldiv in ID during the same window is stalled; it launches in N+L+2.
- If load_use and md_hazard occur together, one stall applies (single bubble per cycle).

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments every cycle in which pc_write=0
  - flush_count increments every cycle in which if_id_flush=1
  - both saturate at 32'hFFFFFFFF and reset to 0
- PIPE_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- lw $5 in EX (ex_MemRead=1, ex_rt_a=5), id_rt_a=5 → exactly one cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rt_a=0 → no stall.
- ex_branch_taken=1 while load_use=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count +1 with PIPE_PERF_CNT_EN.
- mult in ID at cycle N with MUL_LATENCY=4 → md_start at N, md_busy N+1..N+5, hilo_we at N+5 only, IDLE at N+6.
- div launch, then mflo in ID at N+1 → stalled 33 cycles with DIV_LATENCY=32; advances at N+34; stall_cycles=33.
- mult in ID with ex_branch_taken=1 → md_start=0 and state stays IDLE.
- rst_n low at N+2 during a div → md_busy=0 immediately; hilo_we never asserted; counters read 0.
